// File: rtl/wb_master.sv
// Single-transaction Wishbone pipelined master with a request/response front end.
// Transactions are aborted with rsp_err after TIMEOUT_CYCLES cycles without ack.
module wb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_sel,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_addr_o,
   output logic [31:0] wb_data_o,
   output logic [3:0]  wb_sel_o,
   input  logic        wb_ack_i,
   input  logic        wb_stall_i,
   input  logic [31:0] wb_data_i
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   // Last counter value at which the bus may still be held.
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        accept;
   logic        done;
   logic        timeout;
   logic        expire;

   assign req_ready = (state_q == StIdle);
   assign wb_cyc_o  = (state_q != StIdle);
   assign wb_stb_o  = (state_q == StReq);
   assign accept    = (state_q == StIdle) && req_valid;
   assign expire    = (cnt_q == TimeoutLast);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      timeout = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = StReq;
               cnt_d   = '0;
            end
         end
         StReq: begin
            cnt_d = cnt_q + 16'd1;
            // Ack only counts when the strobe is accepted in the same cycle.
            if (!wb_stall_i && wb_ack_i) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if (expire) begin
               timeout = 1'b1;
               state_d = StIdle;
            end else if (!wb_stall_i) begin
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 16'd1;
            if (wb_ack_i) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if (expire) begin
               timeout = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         wb_we_o   <= 1'b0;
         wb_addr_o <= '0;
         wb_data_o <= '0;
         wb_sel_o  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rsp_valid <= done | timeout;
         rsp_err   <= timeout;
         rsp_rdata <= (done && !wb_we_o) ? wb_data_i : '0;
         if (accept) begin
            wb_we_o   <= req_we;
            wb_addr_o <= req_addr;
            wb_data_o <= req_wdata;
            wb_sel_o  <= req_sel;
         end
      end
   end

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master: transfers, stalls, timeout, back-to-back and reset abort.
module tb_wb_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_sel;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_addr_o, wb_data_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i, wb_stall_i;
   logic [31:0] wb_data_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
      .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_data_i(wb_data_i)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_sel   = sel;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
      wb_ack_i = 1'b0; wb_stall_i = 1'b0; wb_data_i = '0;
      tick(); tick();
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000",
                            {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err});
      end
      checks++;
      if ({wb_addr_o, wb_data_o, wb_sel_o, rsp_rdata} !== 100'h0) begin
         errors++; $display("FAIL reset_data got %h want 0",
                            {wb_addr_o, wb_data_o, wb_sel_o, rsp_rdata});
      end
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
      // Request presented together with reset release must be taken on the first edge.
      rst = 1'b0;
      present(1'b1, 32'h4, 32'h5555AAAA, 4'hF);
      tick();
      req_valid = 1'b0;
      checks++;
      if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin
         errors++; $display("FAIL first_accept got %b want 11", {wb_cyc_o, wb_stb_o});
      end
      wb_ack_i = 1'b1;
      tick();
      wb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10) begin
         errors++; $display("FAIL first_rsp got %b want 10", {rsp_valid, rsp_err});
      end
      tick();
   endtask

   task automatic test_write();
      present(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b want 1", req_ready); end
      tick();  // N+1
      req_valid = 1'b0;
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111 || wb_addr_o !== 32'h10 ||
          wb_data_o !== 32'hDEADBEEF || wb_sel_o !== 4'hF) begin
         errors++; $display("FAIL wr_stb got %b %h %h %h want 111 10 deadbeef f",
                            {wb_cyc_o, wb_stb_o, wb_we_o}, wb_addr_o, wb_data_o, wb_sel_o);
      end
      tick();  // N+2
      checks++;
      if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b100) begin
         errors++; $display("FAIL wr_wait got %b want 100", {wb_cyc_o, wb_stb_o, rsp_valid});
      end
      wb_ack_i = 1'b1;
      wb_data_i = 32'h77777777;
      tick();  // N+3
      wb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, wb_cyc_o, req_ready} !== 4'b1001 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL wr_rsp got %b %h want 1001 0",
                            {rsp_valid, rsp_err, wb_cyc_o, req_ready}, rsp_rdata);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b want 0", rsp_valid); end
   endtask

   task automatic test_read();
      present(1'b0, 32'h10, 32'h0, 4'hF);
      tick();
      req_valid = 1'b0;
      checks++;
      if ({wb_stb_o, wb_we_o} !== 2'b10) begin
         errors++; $display("FAIL rd_stb got %b want 10", {wb_stb_o, wb_we_o});
      end
      tick();
      wb_ack_i = 1'b1; wb_data_i = 32'hDEADBEEF;
      tick();
      wb_ack_i = 1'b0; wb_data_i = 32'h0;
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rd_rsp got %b %h want 10 deadbeef", {rsp_valid, rsp_err}, rsp_rdata);
      end
      // Partial-select write, acked in the same cycle as the strobe.
      present(1'b1, 32'h20, 32'h1234, 4'h3);
      tick();
      req_valid = 1'b0;
      checks++;
      if (wb_sel_o !== 4'h3 || wb_data_o !== 32'h1234 || wb_addr_o !== 32'h20) begin
         errors++; $display("FAIL sel_wr got %h %h %h want 3 1234 20", wb_sel_o, wb_data_o, wb_addr_o);
      end
      wb_ack_i = 1'b1; wb_data_i = 32'hFFFFFFFF;
      tick();
      wb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, wb_cyc_o} !== 3'b100 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL imm_ack got %b %h want 100 0", {rsp_valid, rsp_err, wb_cyc_o}, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_stall();
      int stb_cycles = 0;
      present(1'b0, 32'h40, 32'h99, 4'hC);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_stall_i = (i < 3);
         wb_ack_i   = (i == 0);  // ack under stall must be ignored
         if (wb_stb_o === 1'b1) stb_cycles++;
         checks++;
         if (wb_addr_o !== 32'h40 || wb_sel_o !== 4'hC || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_hold got %h %h %b want 40 c 0", wb_addr_o, wb_sel_o, rsp_valid);
         end
         tick();
      end
      wb_stall_i = 1'b0; wb_ack_i = 1'b0;
      checks++;
      if (stb_cycles !== 4 || {wb_cyc_o, wb_stb_o} !== 2'b10) begin
         errors++; $display("FAIL stall_stb got %0d %b want 4 10", stb_cycles, {wb_cyc_o, wb_stb_o});
      end
      wb_ack_i = 1'b1; wb_data_i = 32'hCAFEF00D;
      tick();
      wb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hCAFEF00D) begin
         errors++; $display("FAIL stall_rsp got %b %h want 10 cafef00d", {rsp_valid, rsp_err}, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_timeout();
      int cyc_cycles = 0;
      wb_data_i = 32'hFFFFFFFF;
      present(1'b0, 32'h80, 32'h0, 4'hF);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 20 && wb_cyc_o === 1'b1; i++) begin
         cyc_cycles++;
         tick();
      end
      checks++;
      if (cyc_cycles !== 8) begin errors++; $display("FAIL to_len got %0d want 8", cyc_cycles); end
      checks++;
      if ({rsp_valid, rsp_err, wb_cyc_o} !== 3'b110 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL to_rsp got %b %h want 110 0", {rsp_valid, rsp_err, wb_cyc_o}, rsp_rdata);
      end
      wb_ack_i = 1'b1;  // stray ack
      tick();
      wb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid, wb_cyc_o, req_ready} !== 3'b001) begin
         errors++; $display("FAIL stray_ack got %b want 001", {rsp_valid, wb_cyc_o, req_ready});
      end
      // Ack arriving in the eighth cycle beats the timeout.
      present(1'b0, 32'h84, 32'h0, 4'hF);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      wb_ack_i = 1'b1; wb_data_i = 32'h0BADF00D;
      tick();
      wb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0BADF00D) begin
         errors++; $display("FAIL ack_wins got %b %h want 10 0badf00d", {rsp_valid, rsp_err}, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         present(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF);
         checks++;
         if (req_ready !== 1'b1 || wb_cyc_o !== 1'b0 ||
             (i > 0 && (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1000 + 32'(i - 1)))) begin
            errors++; $display("FAIL b2b_idle%0d got %b %b %b %h", i, req_ready, wb_cyc_o, rsp_valid, rsp_rdata);
         end
         tick();
         checks++;
         if (wb_stb_o !== 1'b1 || req_ready !== 1'b0 || wb_addr_o !== 32'h100 + 32'(4 * i)) begin
            errors++; $display("FAIL b2b_stb%0d got %b %b %h", i, wb_stb_o, req_ready, wb_addr_o);
         end
         wb_ack_i = 1'b1; wb_data_i = 32'h1000 + 32'(i);
         tick();
         wb_ack_i = 1'b0;
      end
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1002) begin
         errors++; $display("FAIL b2b_last got %b %h want 1 1002", rsp_valid, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_reset_in_wait();
      present(1'b1, 32'h200, 32'h11, 4'hF);
      tick();
      req_valid = 1'b0;
      tick();
      checks++;
      if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin
         errors++; $display("FAIL rw_wait got %b want 10", {wb_cyc_o, wb_stb_o});
      end
      #2 rst = 1'b1;
      wb_ack_i = 1'b1;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b000) begin
         errors++; $display("FAIL rw_async got %b want 000", {wb_cyc_o, wb_stb_o, rsp_valid});
      end
      tick();
      rst = 1'b0;
      tick();
      wb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid, wb_cyc_o, req_ready} !== 3'b001) begin
         errors++; $display("FAIL rw_norsp got %b want 001", {rsp_valid, wb_cyc_o, req_ready});
      end
      present(1'b0, 32'h204, 32'h0, 4'hF);
      tick();
      req_valid = 1'b0;
      wb_ack_i = 1'b1; wb_data_i = 32'h600DF00D;
      tick();
      wb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h600DF00D) begin
         errors++; $display("FAIL rw_after got %b %h want 10 600df00d", {rsp_valid, rsp_err}, rsp_rdata);
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_stall();
      test_timeout();
      test_back_to_back();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
